// File: rtl/sprite_line_counter.sv
// Sprite line address generator: takes a sprite descriptor from the print module
// and emits one memory address per pixel tick for a single sprite line.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for sprite_on; descriptor latched on acceptance
// LOAD  | one clk: compute row base, range-check the line index
// EMIT  | one address per pixel_tick until the line is complete
// DONE  | count_finished held (with line_error if any) until sprite_on falls
module sprite_line_counter #(
    parameter int unsigned size_address  = 17,
    parameter int unsigned sprite_width  = 20,
    parameter int unsigned sprite_height = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sprite_on,
    input  logic [31:0]             sprite_datas,
    input  logic                    pixel_tick,
    output logic [size_address-1:0] memory_address,
    output logic                    address_valid,
    output logic                    count_finished,
    output logic                    line_error,
    output logic                    busy
);

    localparam int unsigned COL_W = (sprite_width > 1) ? $clog2(sprite_width) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(sprite_width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [size_address-1:0] base_q;
    logic [4:0]              line_q;
    logic [size_address-1:0] row_base_q;
    logic [COL_W-1:0]        col_q;
    logic [size_address-1:0] memory_address_q;
    logic                    address_valid_q;
    logic                    count_finished_q;
    logic                    line_error_q;
    logic                    busy_q;

    logic [size_address-1:0] row_base_d;
    logic [size_address-1:0] emit_addr_d;
    logic                    line_bad_d;
    logic                    unused_desc;

    // Bits [31:22] of the descriptor carry nothing for this block.
    assign unused_desc = &{1'b0, sprite_datas[31:22]};

    // Address arithmetic wraps modulo 2^size_address by construction of the widths.
    assign row_base_d  = base_q + size_address'(line_q) * size_address'(sprite_width);
    assign emit_addr_d = row_base_q + size_address'(col_q);
    assign line_bad_d  = ({27'd0, line_q} >= sprite_height);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            base_q           <= '0;
            line_q           <= '0;
            row_base_q       <= '0;
            col_q            <= '0;
            memory_address_q <= '0;
            address_valid_q  <= 1'b0;
            count_finished_q <= 1'b0;
            line_error_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    address_valid_q <= 1'b0;
                    if (sprite_on) begin
                        base_q  <= size_address'(sprite_datas[16:0]);
                        line_q  <= sprite_datas[21:17];
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (!sprite_on) begin
                        state_q          <= IDLE;
                        address_valid_q  <= 1'b0;
                        busy_q           <= 1'b0;
                        memory_address_q <= '0;
                    end else begin
                        row_base_q <= row_base_d;
                        col_q      <= '0;
                        if (line_bad_d) begin
                            line_error_q     <= 1'b1;
                            count_finished_q <= 1'b1;
                            busy_q           <= 1'b0;
                            state_q          <= DONE;
                        end else begin
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (!sprite_on) begin
                        // Abort: drop the rest of the line without a finish pulse.
                        state_q          <= IDLE;
                        address_valid_q  <= 1'b0;
                        busy_q           <= 1'b0;
                        memory_address_q <= '0;
                        col_q            <= '0;
                    end else if (pixel_tick) begin
                        memory_address_q <= emit_addr_d;
                        address_valid_q  <= 1'b1;
                        col_q            <= col_q + COL_W'(1);
                        if (col_q == COL_LAST) begin
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end else begin
                        address_valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    address_valid_q <= 1'b0;
                    if (!sprite_on) begin
                        state_q          <= IDLE;
                        count_finished_q <= 1'b0;
                        line_error_q     <= 1'b0;
                        memory_address_q <= '0;
                    end else begin
                        count_finished_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign memory_address = memory_address_q;
    assign address_valid  = address_valid_q;
    assign count_finished = count_finished_q;
    assign line_error     = line_error_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_sprite_line_counter.sv
// Bench for sprite_line_counter: directed and randomized line requests checked
// against an arithmetic model of the expected address sequence and handshake timing.
module tb_sprite_line_counter;

    localparam int AW = 17;
    localparam int SW = 20;
    localparam int SH = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          sprite_on;
    logic [31:0]   sprite_datas;
    logic          pixel_tick;
    logic [AW-1:0] memory_address;
    logic          address_valid;
    logic          count_finished;
    logic          line_error;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic [AW-1:0] obs_q[$];
    int fin_cyc;
    int last_valid_cyc;
    int first_valid_cyc;
    int stable_bad;
    logic err_at_fin;
    int timed_out;

    always #5 clk = ~clk;

    sprite_line_counter #(
        .size_address (AW),
        .sprite_width (SW),
        .sprite_height(SH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sprite_on     (sprite_on),
        .sprite_datas  (sprite_datas),
        .pixel_tick    (pixel_tick),
        .memory_address(memory_address),
        .address_valid (address_valid),
        .count_finished(count_finished),
        .line_error    (line_error),
        .busy          (busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected k-th address of a line: base + line*width + k, wrapped to the address width.
    function automatic logic [AW-1:0] model_addr(input int base, input int line, input int k);
        return AW'((base + line * SW + k) % (1 << AW));
    endfunction

    // Drives one request and records what the DUT does; it makes no judgements itself.
    task automatic run_req(input logic [16:0] base, input logic [4:0] line, input int tick_per,
                           input int stop_after, input int budget);
        logic [AW-1:0] prev;
        int c;
        obs_q.delete();
        fin_cyc = -1;
        last_valid_cyc = -1;
        first_valid_cyc = -1;
        stable_bad = 0;
        err_at_fin = 1'b0;
        timed_out = 1;
        prev = memory_address;
        sprite_datas = {10'($urandom), line, base};
        sprite_on = 1'b1;
        for (c = 1; c <= budget; c++) begin
            if (tick_per == 0) pixel_tick = 1'($urandom_range(0, 1));
            else pixel_tick = ((c % tick_per) == 0);
            cyc();
            if (c == 1) sprite_datas = $urandom;
            if (address_valid) begin
                obs_q.push_back(memory_address);
                last_valid_cyc = c;
                if (first_valid_cyc < 0) first_valid_cyc = c;
            end else if (memory_address !== prev) begin
                stable_bad++;
            end
            prev = memory_address;
            if (count_finished) begin
                fin_cyc = c;
                err_at_fin = line_error;
                timed_out = 0;
                break;
            end
            if (stop_after > 0 && obs_q.size() == stop_after) begin
                timed_out = 0;
                break;
            end
        end
        pixel_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sprite_on = 1'b0;
        pixel_tick = 1'b1;
        sprite_datas = 32'hFFFF_FFFF;
        cyc();
        cyc();
        n_vec++;
        if ({memory_address, address_valid, count_finished, line_error, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_hold outputs got %h exp 0",
                     {memory_address, address_valid, count_finished, line_error, busy});
        end
        reset = 1'b1;
        pixel_tick = 1'b0;
        cyc();
        cyc();
        n_vec++;
        if ({memory_address, address_valid, count_finished, line_error, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_release outputs got %h exp 0",
                     {memory_address, address_valid, count_finished, line_error, busy});
        end
    endtask

    task automatic test_normal();
        run_req(17'h00100, 5'd3, 1, 0, 100);
        n_vec++;
        if (timed_out != 0) begin n_err++; $display("FAIL normal_timeout got no count_finished exp finish"); end
        n_vec++;
        if (obs_q.size() != SW) begin n_err++; $display("FAIL normal_count got %0d exp %0d", obs_q.size(), SW); end
        for (int k = 0; k < obs_q.size() && k < SW; k++) begin
            n_vec++;
            if (obs_q[k] !== model_addr(32'h100, 3, k)) begin
                n_err++;
                $display("FAIL normal_addr[%0d] got %h exp %h", k, obs_q[k], model_addr(32'h100, 3, k));
            end
        end
        n_vec++;
        if (first_valid_cyc != 3) begin n_err++; $display("FAIL normal_first_latency got %0d exp 3", first_valid_cyc); end
        n_vec++;
        if (fin_cyc != last_valid_cyc + 1) begin
            n_err++;
            $display("FAIL normal_finish_latency got %0d exp %0d", fin_cyc, last_valid_cyc + 1);
        end
        n_vec++;
        if (err_at_fin !== 1'b0) begin n_err++; $display("FAIL normal_line_error got %b exp 0", err_at_fin); end
        for (int i = 0; i < 3; i++) begin
            pixel_tick = 1'b1;
            cyc();
            n_vec++;
            if ({count_finished, address_valid, busy} !== 3'b100) begin
                n_err++;
                $display("FAIL normal_done_hold got %b exp 100", {count_finished, address_valid, busy});
            end
        end
        pixel_tick = 1'b0;
        sprite_on = 1'b0;
        cyc();
        n_vec++;
        if ({memory_address, address_valid, count_finished, line_error, busy} !== '0) begin
            n_err++;
            $display("FAIL normal_to_idle outputs got %h exp 0",
                     {memory_address, address_valid, count_finished, line_error, busy});
        end
        cyc();
    endtask

    task automatic test_sparse();
        run_req(17'h00100, 5'd3, 4, 0, 200);
        n_vec++;
        if (timed_out != 0) begin n_err++; $display("FAIL sparse_timeout got no count_finished exp finish"); end
        n_vec++;
        if (obs_q.size() != SW) begin n_err++; $display("FAIL sparse_count got %0d exp %0d", obs_q.size(), SW); end
        for (int k = 0; k < obs_q.size() && k < SW; k++) begin
            n_vec++;
            if (obs_q[k] !== model_addr(32'h100, 3, k)) begin
                n_err++;
                $display("FAIL sparse_addr[%0d] got %h exp %h", k, obs_q[k], model_addr(32'h100, 3, k));
            end
        end
        n_vec++;
        if (stable_bad != 0) begin n_err++; $display("FAIL sparse_addr_stable got %0d changes exp 0", stable_bad); end
        n_vec++;
        if (fin_cyc != last_valid_cyc + 1) begin
            n_err++;
            $display("FAIL sparse_finish_latency got %0d exp %0d", fin_cyc, last_valid_cyc + 1);
        end
        sprite_on = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_wrap();
        run_req(17'h1FFF0, 5'd0, 1, 0, 100);
        n_vec++;
        if (obs_q.size() != SW) begin n_err++; $display("FAIL wrap_count got %0d exp %0d", obs_q.size(), SW); end
        for (int k = 0; k < obs_q.size() && k < SW; k++) begin
            n_vec++;
            if (obs_q[k] !== model_addr(32'h1FFF0, 0, k)) begin
                n_err++;
                $display("FAIL wrap_addr[%0d] got %h exp %h", k, obs_q[k], model_addr(32'h1FFF0, 0, k));
            end
        end
        n_vec++;
        if (err_at_fin !== 1'b0 || timed_out != 0) begin
            n_err++;
            $display("FAIL wrap_finish got err=%b timeout=%0d exp err=0 timeout=0", err_at_fin, timed_out);
        end
        sprite_on = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_illegal();
        run_req(17'h00100, 5'd25, 1, 0, 50);
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL illegal_count got %0d exp 0", obs_q.size()); end
        n_vec++;
        if (fin_cyc != 2) begin n_err++; $display("FAIL illegal_latency got %0d exp 2", fin_cyc); end
        n_vec++;
        if (err_at_fin !== 1'b1) begin n_err++; $display("FAIL illegal_line_error got %b exp 1", err_at_fin); end
        sprite_on = 1'b0;
        cyc();
        n_vec++;
        if ({count_finished, line_error, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL illegal_clear got %b exp 000", {count_finished, line_error, busy});
        end
        cyc();
    endtask

    task automatic test_abort();
        logic [16:0] b;
        logic [4:0] l;
        b = 17'($urandom);
        l = 5'($urandom_range(0, SH - 1));
        run_req(b, l, 1, 7, 100);
        n_vec++;
        if (obs_q.size() != 7) begin n_err++; $display("FAIL abort_count got %0d exp 7", obs_q.size()); end
        for (int k = 0; k < obs_q.size() && k < 7; k++) begin
            n_vec++;
            if (obs_q[k] !== model_addr(int'(b), int'(l), k)) begin
                n_err++;
                $display("FAIL abort_addr[%0d] got %h exp %h", k, obs_q[k], model_addr(int'(b), int'(l), k));
            end
        end
        sprite_on = 1'b0;
        pixel_tick = 1'b1;
        cyc();
        n_vec++;
        if ({address_valid, busy, count_finished} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_idle got %b exp 000", {address_valid, busy, count_finished});
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++;
            if ({address_valid, count_finished} !== 2'b00) begin
                n_err++;
                $display("FAIL abort_quiet got %b exp 00", {address_valid, count_finished});
            end
        end
        pixel_tick = 1'b0;
        run_req(17'h00000, 5'd0, 1, 0, 100);
        n_vec++;
        if (obs_q.size() != SW) begin n_err++; $display("FAIL abort_next_count got %0d exp %0d", obs_q.size(), SW); end
        for (int k = 0; k < obs_q.size() && k < SW; k++) begin
            n_vec++;
            if (obs_q[k] !== AW'(k)) begin
                n_err++;
                $display("FAIL abort_next_addr[%0d] got %h exp %h", k, obs_q[k], AW'(k));
            end
        end
        sprite_on = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_async_reset();
        run_req(17'($urandom), 5'($urandom_range(0, SH - 1)), 1, 5, 100);
        n_vec++;
        if (obs_q.size() != 5 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL areset_setup got count=%0d busy=%b exp count=5 busy=1", obs_q.size(), busy);
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({memory_address, address_valid, count_finished, line_error, busy} !== '0) begin
            n_err++;
            $display("FAIL areset_immediate outputs got %h exp 0",
                     {memory_address, address_valid, count_finished, line_error, busy});
        end
        sprite_on = 1'b0;
        pixel_tick = 1'b1;
        #3;
        reset = 1'b1;
        cyc();
        cyc();
        cyc();
        n_vec++;
        if ({address_valid, busy, count_finished} !== 3'b000) begin
            n_err++;
            $display("FAIL areset_stay_idle got %b exp 000", {address_valid, busy, count_finished});
        end
        sprite_datas = {10'd0, 5'd1, 17'h00040};
        sprite_on = 1'b1;
        cyc();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL areset_restart got busy=%b exp 1", busy); end
        pixel_tick = 1'b0;
        sprite_on = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_random();
        logic [16:0] b;
        logic [4:0] l;
        int tp;
        for (int it = 0; it < 25; it++) begin
            b = 17'($urandom);
            l = 5'($urandom_range(0, 27));
            tp = $urandom_range(0, 3);
            run_req(b, l, tp, 0, 400);
            n_vec++;
            if (timed_out != 0) begin n_err++; $display("FAIL rand%0d_timeout got no count_finished exp finish", it); end
            if (int'(l) < SH) begin
                n_vec++;
                if (obs_q.size() != SW) begin
                    n_err++;
                    $display("FAIL rand%0d_count got %0d exp %0d", it, obs_q.size(), SW);
                end
                for (int k = 0; k < obs_q.size() && k < SW; k++) begin
                    n_vec++;
                    if (obs_q[k] !== model_addr(int'(b), int'(l), k)) begin
                        n_err++;
                        $display("FAIL rand%0d_addr[%0d] got %h exp %h", it, k, obs_q[k],
                                 model_addr(int'(b), int'(l), k));
                    end
                end
                n_vec++;
                if (fin_cyc != last_valid_cyc + 1 || err_at_fin !== 1'b0 || stable_bad != 0) begin
                    n_err++;
                    $display("FAIL rand%0d_finish got fin=%0d err=%b unstable=%0d exp fin=%0d err=0 unstable=0",
                             it, fin_cyc, err_at_fin, stable_bad, last_valid_cyc + 1);
                end
            end else begin
                n_vec++;
                if (obs_q.size() != 0 || fin_cyc != 2 || err_at_fin !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand%0d_illegal got count=%0d fin=%0d err=%b exp count=0 fin=2 err=1",
                             it, obs_q.size(), fin_cyc, err_at_fin);
                end
            end
            sprite_on = 1'b0;
            cyc();
            n_vec++;
            if ({memory_address, address_valid, count_finished, line_error, busy} !== '0) begin
                n_err++;
                $display("FAIL rand%0d_idle outputs got %h exp 0", it,
                         {memory_address, address_valid, count_finished, line_error, busy});
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_sparse();
        test_wrap();
        test_illegal();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
